// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker
//   Watches the count bus of a modulo-(MAX+1) counter. Each clock the new
//   value is compared with the previous one, and the step is classified as
//   HOLD, INC, WRAP (MAX->0) or GLITCH (any other jump). WRAP and GLITCH events
//   are stamped with a free-running cycle counter and queued in a small FIFO.
//   A valid/ready consumer drains that FIFO. A saturating total of wraps is
//   also kept for software.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   count      monitored counter value, sampled each posedge
//   out_valid  FIFO head record valid
//   out_ready  consumer accepts the head record this cycle
//   out_data   {type[1:0], stamp[TS_W-1:0]}; type 01=WRAP, 10=GLITCH
//   fifo_level number of queued records, 0..DEPTH
//   wrap_total saturating count of wraps since reset
//   overflow   sticky flag: a record was dropped because the FIFO was full
module count_wrap_tracker #(
    parameter int N     = 4,
    parameter int MAX   = 5,
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int WC_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W+1:0]            out_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [WC_W-1:0]            wrap_total,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [N-1:0]   MAX_V    = N'(MAX);
    localparam logic [N-1:0]   ONE_N    = N'(1);
    localparam logic [TS_W-1:0] ONE_TS  = TS_W'(1);
    localparam logic [AW-1:0]  ONE_P    = AW'(1);
    localparam logic [AW:0]    ONE_L    = (AW+1)'(1);
    localparam logic [AW:0]    DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [WC_W-1:0] ONE_WC  = WC_W'(1);
    localparam logic [1:0]     TYPE_WRAP   = 2'b01;
    localparam logic [1:0]     TYPE_GLITCH = 2'b10;

    logic [TS_W-1:0]  ts;
    logic [N-1:0]     prev_q;
    logic             primed;
    logic [AW-1:0]    wptr, rptr;
    logic [TS_W+1:0]  mem [DEPTH];

    logic is_hold, is_inc, is_wrap, is_glitch;
    logic push, pop, full, push_ok;

    // Step classification. Nothing is reported until one sample has been
    // taken after reset, since prev_q is not a real observation before that.
    always_comb begin
        is_hold   = (count == prev_q);
        // prev_q < MAX keeps prev_q+1 inside N bits, so no carry is lost.
        is_inc    = (prev_q < MAX_V) && (count == prev_q + ONE_N);
        is_wrap   = primed && (prev_q == MAX_V) && (count == '0);
        is_glitch = primed && !is_hold && !is_inc && !is_wrap;
    end

    assign full      = (fifo_level == DEPTH_L);
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = is_wrap || is_glitch;
    // A pop on the same edge frees the slot the push needs.
    assign push_ok   = push && (!full || pop);

    // Gate the head so the bus reads 0 while empty, including out of reset
    // when the storage itself is not cleared.
    assign out_data  = out_valid ? mem[rptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            prev_q     <= '0;
            primed     <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            wrap_total <= '0;
            overflow   <= 1'b0;
        end else begin
            ts     <= ts + ONE_TS;
            prev_q <= count;
            primed <= 1'b1;

            if (push_ok) wptr <= wptr + ONE_P;
            if (pop)     rptr <= rptr + ONE_P;

            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + ONE_L;
                2'b01:   fifo_level <= fifo_level - ONE_L;
                default: fifo_level <= fifo_level;
            endcase

            // Counted even when the record itself is dropped.
            if (is_wrap && (wrap_total != '1))
                wrap_total <= wrap_total + ONE_WC;

            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Record storage needs no reset: out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wptr] <= {(is_wrap ? TYPE_WRAP : TYPE_GLITCH), ts};
    end

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Directed bench for count_wrap_tracker. A second instance with WC_W=2
// shares the count stimulus so wrap_total saturation can be observed.
module tb_count_wrap_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  count = '0;
    logic        out_ready = 1'b0;

    logic        out_valid;
    logic [17:0] out_data;
    logic [2:0]  fifo_level;
    logic [7:0]  wrap_total;
    logic        overflow;

    logic        ov2, of2;
    logic [17:0] od2;
    logic [2:0]  fl2;
    logic [1:0]  wt2;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    always #5 clk = ~clk;

    count_wrap_tracker #(.N(4), .MAX(5), .TS_W(16), .DEPTH(4), .WC_W(8)) dut (
        .clk(clk), .rst(rst), .count(count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .wrap_total(wrap_total), .overflow(overflow)
    );

    count_wrap_tracker #(.N(4), .MAX(5), .TS_W(16), .DEPTH(4), .WC_W(2)) dut2 (
        .clk(clk), .rst(rst), .count(count),
        .out_valid(ov2), .out_ready(1'b1), .out_data(od2),
        .fifo_level(fl2), .wrap_total(wt2), .overflow(of2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic drive(input logic [3:0] c);
        count = c;
        tick();
    endtask

    // Called 1 time unit after an edge (or at time 0); releases before the next edge.
    task automatic do_reset();
        count     = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        #7;
        rst       = 1'b0;
        ecount    = 0;
    endtask

    task automatic wrap_seq();
        for (int v = 1; v <= 5; v++) drive(4'(v));
        drive(4'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_tests++;
        if ({out_valid, out_data, fifo_level, wrap_total, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b d=%0h l=%0d w=%0d o=%0b, want all 0",
                     out_valid, out_data, fifo_level, wrap_total, overflow);
        end
        do_reset();
    endtask

    task automatic test_free_run();
        do_reset();
        out_ready = 1'b1;
        drive(4'd0);
        for (int w = 0; w < 3; w++) begin
            for (int v = 1; v <= 5; v++) drive(4'(v));
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL free_run_idle[%0d]: out_valid=%0b want 0", w, out_valid);
            end
            drive(4'd0);
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== {2'b01, 16'(6 + 6*w)}) begin
                n_fail++;
                $display("FAIL free_run_wrap[%0d]: v=%0b d=%0h want v=1 d=%0h",
                         w, out_valid, out_data, {2'b01, 16'(6 + 6*w)});
            end
        end
        n_tests++;
        if (wrap_total !== 8'd3 || wt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL free_run_total: got %0d/%0d want 3/3", wrap_total, wt2);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        drive(4'd0); drive(4'd1); drive(4'd2); drive(4'd4);
        n_tests++;
        if (fifo_level !== 3'd1 || out_data !== {2'b10, 16'd3}) begin
            n_fail++;
            $display("FAIL glitch_record: l=%0d d=%0h want l=1 d=%0h", fifo_level, out_data, {2'b10, 16'd3});
        end
        drive(4'd4); drive(4'd4); drive(4'd4);
        n_tests++;
        if (fifo_level !== 3'd1 || out_data !== {2'b10, 16'd3} || wrap_total !== 8'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_hold: l=%0d d=%0h w=%0d o=%0b want l=1 d=%0h w=0 o=0",
                     fifo_level, out_data, wrap_total, overflow, {2'b10, 16'd3});
        end
        out_ready = 1'b1;
        drive(4'd4);
        n_tests++;
        if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_pop: l=%0d v=%0b want l=0 v=0", fifo_level, out_valid);
        end
        drive(4'd4);
        n_tests++;
        if (fifo_level !== 3'd0 || out_data !== 18'd0) begin
            n_fail++;
            $display("FAIL pop_empty: l=%0d d=%0h want l=0 d=0", fifo_level, out_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        drive(4'd0);
        for (int w = 0; w < 5; w++) wrap_seq();
        n_tests++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || wrap_total !== 8'd5) begin
            n_fail++;
            $display("FAIL overflow_state: l=%0d o=%0b w=%0d want l=4 o=1 w=5", fifo_level, overflow, wrap_total);
        end
        n_tests++;
        if (wt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_total_sat: got %0d want 3", wt2);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== {2'b01, 16'(6 + 6*i)}) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: v=%0b d=%0h want v=1 d=%0h",
                         i, out_valid, out_data, {2'b01, 16'(6 + 6*i)});
            end
            drive(4'd0);
        end
        n_tests++;
        if (fifo_level !== 3'd0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: l=%0d o=%0b want l=0 o=1", fifo_level, overflow);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        drive(4'd0);
        for (int w = 0; w < 4; w++) wrap_seq();
        n_tests++;
        if (fifo_level !== 3'd4) begin
            n_fail++;
            $display("FAIL full_level: got %0d want 4", fifo_level);
        end
        for (int v = 1; v <= 5; v++) drive(4'(v));
        out_ready = 1'b1;
        drive(4'd0);
        n_tests++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || wrap_total !== 8'd5) begin
            n_fail++;
            $display("FAIL full_push_pop: l=%0d o=%0b w=%0d want l=4 o=0 w=5", fifo_level, overflow, wrap_total);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== {2'b01, 16'(12 + 6*i)}) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: v=%0b d=%0h want v=1 d=%0h",
                         i, out_valid, out_data, {2'b01, 16'(12 + 6*i)});
            end
            drive(4'd0);
        end
        n_tests++;
        if (fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL full_drained: l=%0d want 0", fifo_level);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'd0);
        wrap_seq();
        wrap_seq();
        n_tests++;
        if (fifo_level !== 3'd2) begin
            n_fail++;
            $display("FAIL pre_reset_level: got %0d want 2", fifo_level);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || wrap_total !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: v=%0b l=%0d w=%0d want 0/0/0", out_valid, fifo_level, wrap_total);
        end
        #3;
        rst    = 1'b0;
        ecount = 0;
        drive(4'd5);
        n_tests++;
        if (fifo_level !== 3'd0) begin
            n_fail++;
            $display("FAIL first_edge_unclassified: l=%0d want 0", fifo_level);
        end
        drive(4'd0);
        n_tests++;
        if (fifo_level !== 3'd1 || out_data !== {2'b01, 16'd1} || wrap_total !== 8'd1) begin
            n_fail++;
            $display("FAIL post_reset_wrap: l=%0d d=%0h w=%0d want l=1 d=%0h w=1",
                     fifo_level, out_data, wrap_total, {2'b01, 16'd1});
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_glitch();
        test_overflow();
        test_full_pop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
